// File: rtl/iter_shift_unit.sv
// Iterative shifter: SHL / SHR / ASHR / ROR, one bit position per clock,
// behind a start/busy/done handshake.
module iter_shift_unit #(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] data_in,
    input  logic [SHW-1:0]   amt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam logic [1:0] OP_SHL  = 2'b00;
    localparam logic [1:0] OP_SHR  = 2'b01;
    localparam logic [1:0] OP_ASHR = 2'b10;
    localparam logic [1:0] OP_ROR  = 2'b11;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] sr_reg, sr_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic [SHW-1:0]   cnt_reg, cnt_next;
    logic [1:0]       op_reg, op_next;
    logic             done_reg, done_next;
    logic [WIDTH-1:0] step;
    logic             fill;
    logic             is_shl;

    // Bit entering at the MSB on right shifts; ASHR reuses the unchanging MSB.
    always_comb begin
        fill = 1'b0;
        case (op_reg)
            OP_ASHR: fill = sr_reg[WIDTH-1];
            OP_ROR:  fill = sr_reg[0];
            OP_SHR:  fill = 1'b0;
            default: fill = 1'b0;
        endcase
    end

    assign is_shl = (op_reg == OP_SHL);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_step
            if (gi == 0) begin : g_lsb
                assign step[gi] = is_shl ? 1'b0 : sr_reg[gi+1];
            end else if (gi == WIDTH-1) begin : g_msb
                assign step[gi] = is_shl ? sr_reg[gi-1] : fill;
            end else begin : g_mid
                assign step[gi] = is_shl ? sr_reg[gi-1] : sr_reg[gi+1];
            end
        end
    endgenerate

    always_comb begin
        state_next  = state_reg;
        sr_next     = sr_reg;
        cnt_next    = cnt_reg;
        op_next     = op_reg;
        result_next = result_reg;
        done_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    sr_next    = data_in;
                    cnt_next   = amt;
                    op_next    = op;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cnt_reg != '0) begin
                    sr_next  = step;
                    cnt_next = cnt_reg - 1'b1;
                end else begin
                    result_next = sr_reg;
                    done_next   = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            sr_reg     <= '0;
            cnt_reg    <= '0;
            op_reg     <= '0;
            result_reg <= '0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            sr_reg     <= sr_next;
            cnt_reg    <= cnt_next;
            op_reg     <= op_next;
            result_reg <= result_next;
            done_reg   <= done_next;
        end
    end

    assign busy   = (state_reg == RUN);
    assign done   = done_reg;
    assign result = result_reg;

endmodule

// File: tb/tb_iter_shift_unit.sv
// Scoreboard bench for iter_shift_unit: driver pushes expected result and
// done cycle, a negedge monitor pops and compares on every done pulse.
module tb_iter_shift_unit;

    localparam int W  = 8;
    localparam int SW = $clog2(W);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    op = 2'b00;
    logic [W-1:0]  data_in = '0;
    logic [SW-1:0] amt = '0;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;

    iter_shift_unit #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .data_in (data_in),
        .amt     (amt),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] res;
        int           cyc;
        int           id;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_id  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Reference: the plain combinational shift operators; rotate via a doubled word.
    function automatic logic [W-1:0] ref_shift(input logic [1:0] o, input logic [W-1:0] d,
                                               input int a);
        logic [2*W-1:0] dd;
        logic [W-1:0]   r;
        dd = {d, d};
        case (o)
            2'b00:   r = d << a;
            2'b01:   r = d >> a;
            2'b10:   r = W'($signed(d) >>> a);
            default: r = W'(dd >> a);
        endcase
        return r;
    endfunction

    // Called at a negedge; leaves at the negedge after the capture edge.
    task automatic issue(input logic [1:0] o, input logic [W-1:0] d, input int a);
        exp_t e;
        int   guard = 0;
        while (busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (busy) begin
            n_cmp++;
            n_bad++;
            $display("FAIL busy_timeout: busy still %b after %0d cycles, want 0", busy, guard);
        end
        start   = 1'b1;
        op      = o;
        data_in = d;
        amt     = SW'(a);
        e.res   = ref_shift(o, d, a);
        e.cyc   = cyc + 1 + a + 1;
        e.id    = n_id++;
        sb.push_back(e);
        $display("issue #%0d op=%0d data=%h amt=%0d expect=%h at cycle %0d",
                 e.id, o, d, a, e.res, e.cyc);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Start pulse while busy: must be ignored entirely.
    task automatic poke_busy();
        start   = 1'b1;
        op      = 2'($urandom_range(0, 3));
        data_in = W'($urandom);
        amt     = SW'($urandom);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Monitor
    initial begin
        logic [W-1:0] last_res;
        exp_t e;
        last_res = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last_res = '0;
            end else if (done) begin
                check("busy_with_done", 32'(busy), 32'd0);
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: result %h with empty scoreboard", result);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("result#%0d", e.id), 32'(result), 32'(e.res));
                    check($sformatf("done_cycle#%0d", e.id), 32'(cyc), 32'(e.cyc));
                    $display("done  #%0d result=%h cycle=%0d", e.id, result, cyc);
                end
                last_res = result;
            end else begin
                check("result_hold", 32'(result), 32'(last_res));
            end
        end
    end

    initial begin
        int guard;
        #23;
        check("reset_busy",   32'(busy),   32'd0);
        check("reset_done",   32'(done),   32'd0);
        check("reset_result", 32'(result), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        issue(2'b00, 8'hA5, 3);
        issue(2'b00, 8'hFF, 7);
        issue(2'b01, 8'hA5, 2);
        issue(2'b10, 8'hA5, 2);
        issue(2'b10, 8'h25, 2);
        issue(2'b11, 8'hA5, 1);
        poke_busy();
        issue(2'b11, 8'hA5, 7);
        poke_busy();
        poke_busy();
        issue(2'b00, 8'h3C, 0);
        poke_busy();
        issue(2'b10, 8'h3C, 0);
        issue(2'b11, 8'h3C, 0);

        // Reset two cycles into an amt=5 SHL
        guard = 0;
        while ((busy || sb.size() != 0) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        issue(2'b00, 8'h81, 5);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_busy",   32'(busy),   32'd0);
        check("async_rst_done",   32'(done),   32'd0);
        check("async_rst_result", 32'(result), 32'd0);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        issue(2'b00, 8'hA5, 3);

        // Random traffic
        for (int i = 0; i < 150; i++) begin
            issue(2'($urandom_range(0, 3)), W'($urandom), int'($urandom_range(0, W-1)));
            if ($urandom_range(0, 3) == 0) poke_busy();
            if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        guard = 0;
        while (sb.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: %0d results outstanding, want 0", sb.size());
        end
        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
